event_ack_ctl: RTL and testbench



---
 rtl/event_ack_ctl.sv | 233 +++++++++++++++++++++++
 tb/tb_event_ack_ctl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/event_ack_ctl.sv
`default_nettype none
// =============================================================================
// event_ack_ctl : frame-buffer ack/nack controller with per-slot retry limit
// Rev 1.0
// =============================================================================
module event_ack_ctl #(
   parameter int NBUF      = 4,
   parameter int MAX_RETRY = 3
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic [31:0] s_event_tdata,
   input  logic        s_event_tvalid,
   output logic        s_event_tready,
   input  logic [15:0] s_cmd_tdata,
   input  logic        s_cmd_tvalid,
   output logic        s_cmd_tready,
   output logic [15:0] m_ack_tdata,
   output logic        m_ack_tvalid,
   input  logic        m_ack_tready,
   output logic [31:0] m_nack_tdata,
   output logic        m_nack_tvalid,
   input  logic        m_nack_tready,
   output logic [6:0]  outstanding_o,
   output logic        err_o,
   output logic        forced_o
);

   localparam int AW = (NBUF > 1) ? $clog2(NBUF) : 1;
   localparam int RW = (MAX_RETRY < 4) ? 2 : $clog2(MAX_RETRY + 1);

   localparam logic [RW-1:0] c_max_retry = RW'(MAX_RETRY);
   localparam logic [AW-1:0] c_last_slot = AW'(NBUF - 1);
   localparam logic [1:0]    c_op_accept = 2'b01;
   localparam logic [1:0]    c_op_resend = 2'b10;

   localparam logic [1:0] c_st_prefill   = 2'd0;
   localparam logic [1:0] c_st_idle      = 2'd1;
   localparam logic [1:0] c_st_send_ack  = 2'd2;
   localparam logic [1:0] c_st_send_nack = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [NBUF-1:0] busy_q, busy_d;
   logic [19:0]   len_q   [NBUF];
   logic [19:0]   len_d   [NBUF];
   logic [RW-1:0] retry_q [NBUF];
   logic [RW-1:0] retry_d [NBUF];
   logic [AW-1:0] pf_addr_q, pf_addr_d;
   logic          rdy_q, rdy_d;
   logic          ack_valid_q, ack_valid_d;
   logic [15:0]   ack_data_q, ack_data_d;
   logic          nack_valid_q, nack_valid_d;
   logic [31:0]   nack_data_q, nack_data_d;
   logic [6:0]    outstanding_q, outstanding_d;
   logic          err_q, err_d;
   logic          forced_q, forced_d;

   logic [AW-1:0] ev_slot;
   logic          ev_fire;
   logic          cmd_fire;
   logic [1:0]    cmd_op;
   logic [11:0]   cmd_addr;
   logic [AW-1:0] cmd_slot;
   logic          cmd_legal;
   logic [RW-1:0] retry_cur;
   logic          do_ack;
   logic          do_nack;
   logic          do_force;
   logic          cmd_err;
   logic          pf_last;
   logic [AW-1:0] pf_next;
   logic          unused_bits;

   // Descriptors take priority: a cmd is only consumed when no descriptor is offered.
   assign ev_slot   = s_event_tdata[20 +: AW];
   assign ev_fire   = rdy_q && s_event_tvalid;
   assign cmd_fire  = rdy_q && s_cmd_tvalid && !s_event_tvalid;
   assign cmd_op    = s_cmd_tdata[15:14];
   assign cmd_addr  = s_cmd_tdata[11:0];
   assign cmd_slot  = cmd_addr[AW-1:0];
   assign cmd_legal = ((cmd_addr >> AW) == 12'd0) && busy_q[cmd_slot] &&
                      ((cmd_op == c_op_accept) || (cmd_op == c_op_resend));
   assign retry_cur = retry_q[cmd_slot];
   assign do_nack   = cmd_fire && cmd_legal && (cmd_op == c_op_resend) &&
                      (retry_cur < c_max_retry);
   assign do_ack    = cmd_fire && cmd_legal && !do_nack;
   assign do_force  = do_ack && (cmd_op == c_op_resend);
   assign cmd_err   = cmd_fire && !cmd_legal;
   assign pf_last   = (pf_addr_q == c_last_slot);
   assign pf_next   = pf_addr_q + AW'(1);

   assign unused_bits = ^{s_event_tdata[31:20+AW], s_cmd_tdata[13:12]};

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= c_st_prefill;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         c_st_prefill: begin
            if (ack_valid_q && m_ack_tready && pf_last) state_d = c_st_idle;
         end
         c_st_idle: begin
            if (do_ack)       state_d = c_st_send_ack;
            else if (do_nack) state_d = c_st_send_nack;
         end
         c_st_send_ack: begin
            if (m_ack_tready) state_d = c_st_idle;
         end
         c_st_send_nack: begin
            if (m_nack_tready) state_d = c_st_idle;
         end
         default: state_d = c_st_prefill;
      endcase
   end

   always_comb begin
      busy_d       = busy_q;
      len_d        = len_q;
      retry_d      = retry_q;
      pf_addr_d    = pf_addr_q;
      ack_valid_d  = ack_valid_q;
      ack_data_d   = ack_data_q;
      nack_valid_d = nack_valid_q;
      nack_data_d  = nack_data_q;
      err_d        = err_q;
      forced_d     = 1'b0;
      case (state_q)
         c_st_prefill: begin
            // Only the final prefill ack grants permission to write.
            if (!ack_valid_q) begin
               ack_valid_d = 1'b1;
               ack_data_d  = {pf_last, 3'b000, {(12-AW){1'b0}}, pf_addr_q};
            end else if (m_ack_tready) begin
               if (pf_last) begin
                  ack_valid_d = 1'b0;
                  pf_addr_d   = '0;
               end else begin
                  pf_addr_d  = pf_next;
                  ack_data_d = {(pf_next == c_last_slot), 3'b000, {(12-AW){1'b0}}, pf_next};
               end
            end
         end
         c_st_idle: begin
            if (ev_fire) begin
               if (busy_q[ev_slot]) err_d = 1'b1;
               busy_d[ev_slot] = 1'b1;
               len_d[ev_slot]  = s_event_tdata[19:0];
            end
            if (cmd_err) err_d = 1'b1;
            if (do_ack) begin
               busy_d[cmd_slot]  = 1'b0;
               retry_d[cmd_slot] = '0;
               ack_valid_d       = 1'b1;
               ack_data_d        = {1'b1, 3'b000, cmd_addr};
               forced_d          = do_force;
            end
            if (do_nack) begin
               busy_d[cmd_slot]  = 1'b0;
               retry_d[cmd_slot] = retry_cur + RW'(1);
               nack_valid_d      = 1'b1;
               nack_data_d       = {cmd_addr, len_q[cmd_slot]};
            end
         end
         c_st_send_ack: begin
            if (m_ack_tready) ack_valid_d = 1'b0;
         end
         c_st_send_nack: begin
            if (m_nack_tready) nack_valid_d = 1'b0;
         end
         default: begin
            ack_valid_d  = 1'b0;
            nack_valid_d = 1'b0;
         end
      endcase

      rdy_d = (state_d == c_st_idle);

      outstanding_d = '0;
      for (int i = 0; i < NBUF; i++) begin
         outstanding_d = outstanding_d + 7'(busy_d[i]);
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         busy_q        <= '0;
         for (int i = 0; i < NBUF; i++) begin
            len_q[i]   <= '0;
            retry_q[i] <= '0;
         end
         pf_addr_q     <= '0;
         rdy_q         <= 1'b0;
         ack_valid_q   <= 1'b0;
         ack_data_q    <= '0;
         nack_valid_q  <= 1'b0;
         nack_data_q   <= '0;
         outstanding_q <= '0;
         err_q         <= 1'b0;
         forced_q      <= 1'b0;
      end else begin
         busy_q        <= busy_d;
         len_q         <= len_d;
         retry_q       <= retry_d;
         pf_addr_q     <= pf_addr_d;
         rdy_q         <= rdy_d;
         ack_valid_q   <= ack_valid_d;
         ack_data_q    <= ack_data_d;
         nack_valid_q  <= nack_valid_d;
         nack_data_q   <= nack_data_d;
         outstanding_q <= outstanding_d;
         err_q         <= err_d;
         forced_q      <= forced_d;
      end
   end

   assign s_event_tready = rdy_q;
   assign s_cmd_tready   = rdy_q;
   assign m_ack_tvalid   = ack_valid_q;
   assign m_ack_tdata    = ack_data_q;
   assign m_nack_tvalid  = nack_valid_q;
   assign m_nack_tdata   = nack_data_q;
   assign outstanding_o  = outstanding_q;
   assign err_o          = err_q;
   assign forced_o       = forced_q;

endmodule
`default_nettype wire

// File: tb/tb_event_ack_ctl.sv
`default_nettype none
// =============================================================================
// tb_event_ack_ctl : directed self-checking bench for event_ack_ctl
// Rev 1.0
// =============================================================================
module tb_event_ack_ctl;

   logic        clk = 1'b0;
   logic        aresetn = 1'b0;
   logic [31:0] s_event_tdata = '0;
   logic        s_event_tvalid = 1'b0;
   logic        s_event_tready;
   logic [15:0] s_cmd_tdata = '0;
   logic        s_cmd_tvalid = 1'b0;
   logic        s_cmd_tready;
   logic [15:0] m_ack_tdata;
   logic        m_ack_tvalid;
   logic        m_ack_tready = 1'b1;
   logic [31:0] m_nack_tdata;
   logic        m_nack_tvalid;
   logic        m_nack_tready = 1'b1;
   logic [6:0]  outstanding_o;
   logic        err_o;
   logic        forced_o;

   int checks = 0;
   int errors = 0;

   logic [15:0] pf_exp [4] = '{16'h0000, 16'h0001, 16'h0002, 16'h8003};

   always #5 clk = ~clk;

   event_ack_ctl #(.NBUF(4), .MAX_RETRY(3)) dut (
      .aclk           (clk),
      .aresetn        (aresetn),
      .s_event_tdata  (s_event_tdata),
      .s_event_tvalid (s_event_tvalid),
      .s_event_tready (s_event_tready),
      .s_cmd_tdata    (s_cmd_tdata),
      .s_cmd_tvalid   (s_cmd_tvalid),
      .s_cmd_tready   (s_cmd_tready),
      .m_ack_tdata    (m_ack_tdata),
      .m_ack_tvalid   (m_ack_tvalid),
      .m_ack_tready   (m_ack_tready),
      .m_nack_tdata   (m_nack_tdata),
      .m_nack_tvalid  (m_nack_tvalid),
      .m_nack_tready  (m_nack_tready),
      .outstanding_o  (outstanding_o),
      .err_o          (err_o),
      .forced_o       (forced_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Reset asserted at a falling edge, released two cycles later.
   task automatic apply_reset();
      aresetn        = 1'b0;
      s_event_tvalid = 1'b0;
      s_cmd_tvalid   = 1'b0;
      m_ack_tready   = 1'b1;
      m_nack_tready  = 1'b1;
      repeat (2) @(negedge clk);
      aresetn = 1'b1;
   endtask

   task automatic run_prefill(input bit toggle);
      int idx = 0;
      for (int cyc = 0; cyc < 24 && idx < 4; cyc++) begin
         @(negedge clk);
         check("pf_valid", {31'd0, m_ack_tvalid}, 32'd1);
         check("pf_data", {16'd0, m_ack_tdata}, {16'd0, pf_exp[idx]});
         m_ack_tready = toggle ? cyc[0] : 1'b1;
         if (m_ack_tready) idx++;
      end
      m_ack_tready = 1'b1;
      @(negedge clk);
      check("pf_done_evrdy", {31'd0, s_event_tready}, 32'd1);
      check("pf_done_ackvalid", {31'd0, m_ack_tvalid}, 32'd0);
   endtask

   task automatic send_event(input logic [11:0] addr, input logic [19:0] len);
      s_event_tdata  = {addr, len};
      s_event_tvalid = 1'b1;
      @(negedge clk);
      s_event_tvalid = 1'b0;
   endtask

   task automatic send_cmd(input logic [15:0] cmd);
      s_cmd_tdata  = cmd;
      s_cmd_tvalid = 1'b1;
      @(negedge clk);
      s_cmd_tvalid = 1'b0;
   endtask

   initial begin
      // Reset values
      @(negedge clk);
      check("rst_ack_valid", {31'd0, m_ack_tvalid}, 32'd0);
      check("rst_ack_data", {16'd0, m_ack_tdata}, 32'd0);
      check("rst_nack_valid", {31'd0, m_nack_tvalid}, 32'd0);
      check("rst_nack_data", m_nack_tdata, 32'd0);
      check("rst_ev_rdy", {31'd0, s_event_tready}, 32'd0);
      check("rst_cmd_rdy", {31'd0, s_cmd_tready}, 32'd0);
      check("rst_outstanding", {25'd0, outstanding_o}, 32'd0);
      check("rst_err", {31'd0, err_o}, 32'd0);
      check("rst_forced", {31'd0, forced_o}, 32'd0);

      // Prefill, back-to-back then stalled
      aresetn = 1'b1;
      run_prefill(1'b0);
      apply_reset();
      run_prefill(1'b1);

      // Accept
      send_event(12'h000, 20'd3200);
      check("acc_outstanding1", {25'd0, outstanding_o}, 32'd1);
      send_cmd(16'h4000);
      check("acc_ack_valid", {31'd0, m_ack_tvalid}, 32'd1);
      check("acc_ack_data", {16'd0, m_ack_tdata}, 32'h0000_8000);
      check("acc_outstanding0", {25'd0, outstanding_o}, 32'd0);
      check("acc_forced", {31'd0, forced_o}, 32'd0);
      @(negedge clk);
      check("acc_ack_done", {31'd0, m_ack_tvalid}, 32'd0);

      // Resend then re-descriptor and accept
      send_event(12'h001, 20'd3840);
      send_cmd(16'h8001);
      check("rs_nack_valid", {31'd0, m_nack_tvalid}, 32'd1);
      check("rs_nack_data", m_nack_tdata, 32'h0010_0F00);
      check("rs_ack_valid", {31'd0, m_ack_tvalid}, 32'd0);
      @(negedge clk);
      check("rs_nack_done", {31'd0, m_nack_tvalid}, 32'd0);
      send_event(12'h001, 20'd3840);
      send_cmd(16'h4001);
      check("rs_ack_data", {16'd0, m_ack_tdata}, 32'h0000_8001);
      check("rs_ack_valid2", {31'd0, m_ack_tvalid}, 32'd1);
      @(negedge clk);

      // Retry limit on slot 2
      for (int r = 0; r < 3; r++) begin
         send_event(12'h002, 20'(100 + r));
         send_cmd(16'h8002);
         check("rl_nack_valid", {31'd0, m_nack_tvalid}, 32'd1);
         check("rl_nack_data", m_nack_tdata, {12'h002, 20'(100 + r)});
         check("rl_forced0", {31'd0, forced_o}, 32'd0);
         @(negedge clk);
      end
      send_event(12'h002, 20'd200);
      send_cmd(16'h8002);
      check("rl_force_ack_valid", {31'd0, m_ack_tvalid}, 32'd1);
      check("rl_force_ack_data", {16'd0, m_ack_tdata}, 32'h0000_8002);
      check("rl_force_nack", {31'd0, m_nack_tvalid}, 32'd0);
      check("rl_forced1", {31'd0, forced_o}, 32'd1);
      @(negedge clk);
      check("rl_forced_pulse", {31'd0, forced_o}, 32'd0);
      check("rl_outstanding", {25'd0, outstanding_o}, 32'd0);
      check("rl_no_err", {31'd0, err_o}, 32'd0);
      // Retry counter cleared by the forced ack: next resend nacks again
      send_event(12'h002, 20'd300);
      send_cmd(16'h8002);
      check("rl_retry_cleared", {31'd0, m_nack_tvalid}, 32'd1);
      @(negedge clk);

      // Error: verdict on idle slot
      send_cmd(16'h4003);
      check("e1_ack", {31'd0, m_ack_tvalid}, 32'd0);
      check("e1_nack", {31'd0, m_nack_tvalid}, 32'd0);
      check("e1_err", {31'd0, err_o}, 32'd1);
      check("e1_consumed", {31'd0, s_cmd_tready}, 32'd1);

      // Error: addr out of range (slot 1 busy so only the range is wrong)
      apply_reset();
      run_prefill(1'b0);
      send_event(12'h001, 20'd50);
      check("e2_err_pre", {31'd0, err_o}, 32'd0);
      send_cmd(16'h4005);
      check("e2_ack", {31'd0, m_ack_tvalid}, 32'd0);
      check("e2_err", {31'd0, err_o}, 32'd1);
      check("e2_outstanding", {25'd0, outstanding_o}, 32'd1);

      // Error: illegal op 11, slot stays busy, then legal accept, err held
      apply_reset();
      run_prefill(1'b0);
      send_event(12'h001, 20'd60);
      send_cmd(16'hC001);
      check("e3_ack", {31'd0, m_ack_tvalid}, 32'd0);
      check("e3_nack", {31'd0, m_nack_tvalid}, 32'd0);
      check("e3_err", {31'd0, err_o}, 32'd1);
      check("e3_outstanding", {25'd0, outstanding_o}, 32'd1);
      send_cmd(16'h4001);
      check("e3_accept_after", {16'd0, m_ack_tdata}, 32'h0000_8001);
      check("e3_err_held", {31'd0, err_o}, 32'd1);
      @(negedge clk);

      // Error: descriptor to busy slot overwrites len
      apply_reset();
      run_prefill(1'b0);
      send_event(12'h001, 20'd10);
      send_event(12'h001, 20'd20);
      check("e4_err", {31'd0, err_o}, 32'd1);
      check("e4_outstanding", {25'd0, outstanding_o}, 32'd1);
      send_cmd(16'h8001);
      check("e4_nack_len", m_nack_tdata, 32'h0010_0014);
      @(negedge clk);

      // Collision: descriptor wins, cmd accepted on next IDLE cycle
      apply_reset();
      run_prefill(1'b0);
      s_event_tdata  = {12'h003, 20'd77};
      s_event_tvalid = 1'b1;
      s_cmd_tdata    = 16'h4003;
      s_cmd_tvalid   = 1'b1;
      @(negedge clk);
      s_event_tvalid = 1'b0;
      check("col_outstanding", {25'd0, outstanding_o}, 32'd1);
      check("col_no_ack_yet", {31'd0, m_ack_tvalid}, 32'd0);
      @(negedge clk);
      s_cmd_tvalid = 1'b0;
      check("col_ack_valid", {31'd0, m_ack_tvalid}, 32'd1);
      check("col_ack_data", {16'd0, m_ack_tdata}, 32'h0000_8003);
      check("col_err", {31'd0, err_o}, 32'd0);
      @(negedge clk);

      // Reset while nack pending
      send_event(12'h000, 20'd10);
      m_nack_tready = 1'b0;
      send_cmd(16'h8000);
      check("rn_nack_valid", {31'd0, m_nack_tvalid}, 32'd1);
      @(negedge clk);
      check("rn_nack_stalled", {31'd0, m_nack_tvalid}, 32'd1);
      aresetn = 1'b0;
      #1;
      check("rn_nack_dropped", {31'd0, m_nack_tvalid}, 32'd0);
      check("rn_outstanding", {25'd0, outstanding_o}, 32'd0);
      m_nack_tready = 1'b1;
      @(negedge clk);
      aresetn = 1'b1;
      run_prefill(1'b0);
      check("rn_nack_after", {31'd0, m_nack_tvalid}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
